// File: rtl/logic_seq_pkg.sv
// Shared op codes, FSM state encoding and counter sizing for the sequential logic unit.
package logic_seq_pkg;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_NOR    = 3'b011;
  localparam logic [2:0] OP_NAND   = 3'b100;
  localparam logic [2:0] OP_XNOR   = 3'b101;
  localparam logic [2:0] OP_ANDN   = 3'b110;
  localparam logic [2:0] OP_PASS_A = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice counter needs at least one bit even when there is a single slice.
  function automatic int unsigned cnt_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise logic cell; all eight op codes are defined.
module logic_slice
  import logic_seq_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] res
);

  always_comb begin
    res = '0;
    unique case (op)
      OP_AND:    res = a & b;
      OP_OR:     res = a | b;
      OP_XOR:    res = a ^ b;
      OP_NOR:    res = ~(a | b);
      OP_NAND:   res = ~(a & b);
      OP_XNOR:   res = ~(a ^ b);
      OP_ANDN:   res = a & ~b;
      OP_PASS_A: res = a;
    endcase
  end

endmodule

// File: rtl/logic_seq_unit.sv
// Handshaked bitwise logic unit evaluating SLICE bits per cycle, LSB slice first.
// Optional zero/parity result flags are enabled with the LOGIC_SEQ_FLAGS_EN macro.
module logic_seq_unit
  import logic_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_SEQ_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = cnt_width(NSLICE);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, data_q;
  logic [2:0]       op_q;
  logic [SLICE-1:0] a_sl, b_sl, res_sl;
  logic             accept, last;
  int unsigned      base;

  assign in_ready  = (state_q == ST_IDLE) && rst_n;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CW'(NSLICE - 1));

  always_comb begin
    base = 32'(cnt_q) * SLICE;
    a_sl = a_q[base +: SLICE];
    b_sl = b_q[base +: SLICE];
  end

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .op  (op_q),
    .res (res_sl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (last) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        op_q  <= in_op;
        cnt_q <= '0;
      end else if (state_q == ST_BUSY) begin
        data_q[base +: SLICE] <= res_sl;
        cnt_q                 <= last ? '0 : cnt_q + CW'(1);
      end
    end
  end

`ifdef LOGIC_SEQ_FLAGS_EN
  logic zero_q, parity_q;

  assign out_zero   = zero_q;
  assign out_parity = parity_q;

  // Flags fold in one slice per BUSY cycle, so they settle together with the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept) begin
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      zero_q   <= zero_q & ~(|res_sl);
      parity_q <= parity_q ^ (^res_sl);
    end
  end
`endif

endmodule

// File: doc/logic_seq_unit.md
Name: logic_seq_unit

Overview:
- Parametrised, handshaked successor to the 32-bit combinational bitwise logic unit.
- Takes WIDTH-bit operands and a 3-bit op code, latches them, and evaluates the op SLICE bits per cycle, LSB slice first.
- Holds the result until the consumer accepts it.
- Sits between the operand-fetch stage and writeback. It trades latency for area when a wide datapath is used.

Parameters:
- WIDTH, 32: operand and result width. Must be a multiple of SLICE.
- SLICE, 8: bits evaluated per cycle. NSLICE = WIDTH/SLICE, with 1 <= NSLICE <= 64.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: operand request.
- in_ready, output, 1: block can accept a request.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_op, input, 3: operation select.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, WIDTH: result.

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NOR. Low four codes are identical to the legacy 2-bit select.
  - 100 NAND, 101 XNOR, 110 ANDN (a & ~b), 111 PASS_A.
  - All 8 codes are defined; there is no illegal op.
- States:
  - IDLE → BUSY on in_valid && in_ready. At that edge in_a, in_b and in_op are latched and slice counter cnt = 0.
  - BUSY: each cycle computes slice cnt into result bits [cnt*SLICE +: SLICE], then cnt++. When cnt == NSLICE-1 is processed, go to DONE.
  - DONE → IDLE on out_ready.
- Handshake outputs:
  - in_ready = (state == IDLE) && rst_n. It is combinational from state only; there is no path from out_ready to in_ready.
  - out_valid = (state == DONE), registered.
- Latency: out_valid rises NSLICE cycles after the accepting edge. Minimum op-to-op spacing is NSLICE+2 cycles when out_ready is held high.
- Input isolation: changes to in_a, in_b and in_op during BUSY or DONE are ignored, because the operands are latched. in_valid outside IDLE is ignored, with no queueing.
- Backpressure: in DONE with out_ready low, out_data and out_valid hold stable indefinitely.
- out_data is updated only in BUSY. In IDLE it retains the last result.
- Reset values: state IDLE, cnt 0, out_valid 0, out_data 0, latched operands 0. A reset asserted mid-BUSY or mid-DONE aborts the operation; no partial result is ever flagged valid.
- Width rules: all ops are pure bitwise, with no carry between slices. When NSLICE = 1 the block degenerates to a registered single-cycle unit, with out_valid one cycle after accept.

Optional Feature:
- Macro: LOGIC_SEQ_FLAGS_EN.
- When defined, adds two output ports:
  - out_zero, 1: result == 0.
  - out_parity, 1: XOR-reduction of the result.
- Flag accumulation: both flags are accumulated per slice during BUSY. The accumulator initialises to zero=1, parity=0 on accept.
- Flag timing: flags are valid and stable whenever out_valid = 1, and reset to 0.
- When the macro is undefined, the ports and accumulators are absent and behaviour is otherwise identical.

Decomposition:
- Package logic_seq_pkg:
  - op code localparams OP_AND … OP_PASS_A;
  - state encoding ST_IDLE, ST_BUSY, ST_DONE;
  - width-of-counter helper (clog2 of NSLICE).
- Sub-module logic_slice (combinational, parametrised by SLICE): SLICE-bit a, b, 3-bit op in, SLICE-bit result out. It is the generalised per-bit cell, instantiated once and fed by the cnt-indexed operand slice.

Test Plan (WIDTH=32, SLICE=8 unless noted):
- Basic AND:
  - Stimulus: op=000, a=0x0000_0006, b=0x0000_000C, accepted at edge 0, out_ready=1.
  - Response: out_valid high after edge 4, out_data=0x0000_0004, in_ready high again after edge 5.
- Op sweep with a=0xF0F0_1234, b=0x0FF0_FFFF. Each result must be bit-exact:
  - AND = 0x00F0_1234; OR = 0xFFF0_FFFF; XOR = 0xFF00_EDCB; NOR = 0x000F_0000.
  - NAND = 0xFF0F_EDCB; XNOR = 0x00FF_1234; ANDN = 0xF000_0000; PASS_A = 0xF0F0_1234.
- Backpressure:
  - Stimulus: out_ready low for 6 cycles in DONE, in_valid pulsed with new operands.
  - Response: out_data and out_valid hold, in_ready = 0, new request ignored. After out_ready, the next accepted op is computed correctly.
- Reset mid-operation:
  - Stimulus: rst_n low at the second BUSY edge.
  - Response: next cycle out_valid=0, out_data=0, in_ready=1. The following OR of 0x1/0x2 yields 0x3.
- Flags (LOGIC_SEQ_FLAGS_EN):
  - XOR with a=b=0x1234_5678 → out_data=0, out_zero=1, out_parity=0.
  - OR with a=0x1, b=0 → out_zero=0, out_parity=1.
- Degenerate case (SLICE=32): XNOR of 0xFFFF_0000 and 0x0000_0000 → out_valid one cycle after accept, out_data=0x0000_FFFF.
